// File: rtl/booth_seq_mul.sv
// Sequential radix-4 Booth multiplier with valid/ready handshakes on both sides.
// DIG_PER_CYC Booth digits are folded per clock into a carry-save pair, resolved by one adder.
module booth_seq_mul #(
   parameter int A_LEN       = 256,
   parameter int B_LEN       = 64,
   parameter int DIG_PER_CYC = 4,
   parameter int P_LEN       = A_LEN + B_LEN,
   parameter int NDIG        = B_LEN / 2 + 1,
   parameter int NCYC        = (NDIG + DIG_PER_CYC - 1) / DIG_PER_CYC
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [A_LEN-1:0] a,
   input  logic [B_LEN-1:0] b,
   input  logic             tc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [P_LEN-1:0] p,
   output logic             busy
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam int BS_LEN = B_LEN + 3;
   localparam int CW = (NCYC > 1) ? $clog2(NCYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(NCYC - 1);

   logic [1:0]        state_r;
   logic [CW-1:0]     cnt_r;
   logic [P_LEN-1:0]  acc_r;
   logic [P_LEN-1:0]  mcand_r;
   logic [P_LEN-1:0]  p_r;
   logic [BS_LEN-1:0] mplr_r;
   logic              out_valid_r;
   logic              accept_s;
   logic              last_s;
   logic [P_LEN-1:0]  sum_s;
   logic [P_LEN-1:0]  carry_s;
   logic [P_LEN-1:0]  pp_s;
   logic [P_LEN-1:0]  acc_next_s;

   function automatic logic [P_LEN-1:0] booth_pp(input logic [2:0] dig, input logic [P_LEN-1:0] m);
      logic [P_LEN-1:0] r;
      case (dig)
         3'b001, 3'b010: r = m;
         3'b011:         r = m << 1;
         3'b100:         r = {P_LEN{1'b0}} - (m << 1);
         3'b101, 3'b110: r = {P_LEN{1'b0}} - m;
         default:        r = {P_LEN{1'b0}};
      endcase
      return r;
   endfunction

   assign in_ready  = (state_r == S_IDLE) | ((state_r == S_DONE) & out_ready);
   assign accept_s  = in_valid & in_ready;
   assign last_s    = (cnt_r == CNT_LAST);
   assign out_valid = out_valid_r;
   assign p         = p_r;
   assign busy      = (state_r != S_IDLE);

   // Digits past NDIG in the final cycle contribute nothing
   always_comb begin
      sum_s   = acc_r;
      carry_s = {P_LEN{1'b0}};
      pp_s    = {P_LEN{1'b0}};
      for (int j = 0; j < DIG_PER_CYC; j++) begin
         if (int'(cnt_r) * DIG_PER_CYC + j < NDIG) begin
            pp_s = booth_pp(mplr_r[2*j +: 3], mcand_r << (2*j));
         end else begin
            pp_s = {P_LEN{1'b0}};
         end
         {carry_s, sum_s} = {((sum_s & carry_s) | (sum_s & pp_s) | (carry_s & pp_s)) << 1,
                             sum_s ^ carry_s ^ pp_s};
      end
      acc_next_s = sum_s + carry_s;
   end

   // Handshake FSM; multiplicand/multiplier shift so digit j of each cycle sits at fixed bits
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= S_IDLE;
         cnt_r       <= {CW{1'b0}};
         acc_r       <= {P_LEN{1'b0}};
         mcand_r     <= {P_LEN{1'b0}};
         mplr_r      <= {BS_LEN{1'b0}};
         p_r         <= {P_LEN{1'b0}};
         out_valid_r <= 1'b0;
      end else if (accept_s) begin
         state_r     <= S_RUN;
         cnt_r       <= {CW{1'b0}};
         acc_r       <= {P_LEN{1'b0}};
         mcand_r     <= {{B_LEN{tc & a[A_LEN-1]}}, a};
         mplr_r      <= {{2{tc & b[B_LEN-1]}}, b, 1'b0};
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            S_RUN: begin
               acc_r   <= acc_next_s;
               mcand_r <= mcand_r << (2 * DIG_PER_CYC);
               mplr_r  <= mplr_r >> (2 * DIG_PER_CYC);
               cnt_r   <= cnt_r + 1'b1;
               if (last_s) begin
                  state_r     <= S_DONE;
                  cnt_r       <= {CW{1'b0}};
                  p_r         <= acc_next_s;
                  out_valid_r <= 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state_r     <= S_IDLE;
                  out_valid_r <= 1'b0;
               end
            end
            S_IDLE: state_r <= S_IDLE;
            default: begin
               state_r     <= S_IDLE;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_booth_seq_mul.sv
// Self-checking bench for booth_seq_mul: directed vector table, handshake corner sequences,
// and randomized traffic against a plain-arithmetic reference product.
module tb_booth_seq_mul;
   localparam int A_LEN = 256;
   localparam int B_LEN = 64;
   localparam int DPC   = 4;
   localparam int P_LEN = A_LEN + B_LEN;
   localparam int NCYC  = 9;
   localparam int NRAND = 400;
   localparam logic [P_LEN-1:0] ONE_P = 1;
   localparam logic [A_LEN-1:0] ONE_A = 1;
   localparam logic [B_LEN-1:0] ONE_B = 1;
   localparam logic [A_LEN-1:0] A_ALL = {A_LEN{1'b1}};
   localparam logic [B_LEN-1:0] B_ALL = {B_LEN{1'b1}};
   localparam logic [A_LEN-1:0] A_MIX = (ONE_A << 255) | A_LEN'(5);

   logic clk = 1'b0;
   logic rst, in_valid, in_ready, tc, out_valid, out_ready, busy;
   logic [A_LEN-1:0] a;
   logic [B_LEN-1:0] b;
   logic [P_LEN-1:0] p;
   int n_tests = 0;
   int n_fail = 0;

   typedef struct {
      string            name;
      logic [A_LEN-1:0] a;
      logic [B_LEN-1:0] b;
      logic             tc;
      logic [P_LEN-1:0] exp;
   } vec_t;
   vec_t vecs[$];

   always #5 clk = ~clk;

   booth_seq_mul #(.A_LEN(A_LEN), .B_LEN(B_LEN), .DIG_PER_CYC(DPC)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .tc(tc),
      .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy));

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [P_LEN-1:0] act, input logic [P_LEN-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: extend both operands to the product width and multiply modulo 2^P_LEN
   function automatic logic [P_LEN-1:0] ref_mul(input logic [A_LEN-1:0] x, input logic [B_LEN-1:0] y,
                                                input logic s);
      logic [P_LEN-1:0] xe, ye;
      xe = {{B_LEN{s & x[A_LEN-1]}}, x};
      ye = {{A_LEN{s & y[B_LEN-1]}}, y};
      return xe * ye;
   endfunction

   function automatic logic [A_LEN-1:0] rand_a();
      logic [A_LEN-1:0] r;
      for (int i = 0; i < A_LEN / 32; i++) r[32*i +: 32] = $urandom;
      case ($urandom_range(0, 7))
         0: r = {A_LEN{1'b0}};
         1: r = A_ALL;
         2: r = ONE_A << 255;
         3: r = A_LEN'($urandom_range(0, 20));
         default: r = r;
      endcase
      return r;
   endfunction

   function automatic logic [B_LEN-1:0] rand_b();
      logic [B_LEN-1:0] r;
      r = {$urandom, $urandom};
      case ($urandom_range(0, 7))
         0: r = {B_LEN{1'b0}};
         1: r = B_ALL;
         2: r = ONE_B << 63;
         3: r = B_LEN'($urandom_range(0, 20));
         default: r = r;
      endcase
      return r;
   endfunction

   task automatic add_vec(input string nm, input logic [A_LEN-1:0] av, input logic [B_LEN-1:0] bv,
                          input logic t, input logic [P_LEN-1:0] ev);
      vec_t v;
      v.name = nm; v.a = av; v.b = bv; v.tc = t; v.exp = ev;
      vecs.push_back(v);
   endtask

   // Waits (bounded) for out_valid; lat counts edges since the accept edge
   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_op(input string nm, input logic [A_LEN-1:0] av, input logic [B_LEN-1:0] bv,
                         input logic t, input logic [P_LEN-1:0] ev);
      int lat;
      @(negedge clk);
      a = av; b = bv; tc = t; in_valid = 1'b1; out_ready = 1'b1;
      #1 check({nm, " in_ready"}, P_LEN'(in_ready), ONE_P);
      @(negedge clk);
      in_valid = 1'b0;
      check({nm, " busy"}, P_LEN'(busy), ONE_P);
      wait_out(lat);
      check({nm, " latency"}, P_LEN'(lat), P_LEN'(NCYC));
      check({nm, " p"}, p, ev);
      @(negedge clk);
      check({nm, " valid drop"}, P_LEN'(out_valid), {P_LEN{1'b0}});
      check({nm, " p retained"}, p, ev);
   endtask

   initial begin
      int lat;
      int sent, recv, cyc;
      logic prev_hold;
      logic [P_LEN-1:0] prev_p;
      logic [P_LEN-1:0] expq[$];

      add_vec("umax",    A_ALL, B_ALL, 1'b0, {P_LEN{1'b0}} - (ONE_P << 256) - (ONE_P << 64) + ONE_P);
      add_vec("s_m1m1",  A_ALL, B_ALL, 1'b1, ONE_P);
      add_vec("s_minmin", ONE_A << 255, ONE_B << 63, 1'b1, ONE_P << 318);
      add_vec("s_5xm3",  A_LEN'(5), {B_LEN{1'b0}} - B_LEN'(3), 1'b1, {P_LEN{1'b0}} - P_LEN'(15));
      add_vec("zero_a",  {A_LEN{1'b0}}, 64'hDEAD_BEEF_1234_5678, 1'b1, {P_LEN{1'b0}});
      add_vec("id_u",    A_MIX, ONE_B, 1'b0, {{B_LEN{1'b0}}, A_MIX});
      add_vec("id_s",    A_MIX, ONE_B, 1'b1, {{B_LEN{1'b1}}, A_MIX});
      add_vec("s_7xm2",  A_LEN'(7), {B_LEN{1'b0}} - B_LEN'(2), 1'b1, {P_LEN{1'b0}} - P_LEN'(14));
      add_vec("u_3xbig", A_LEN'(3), {B_LEN{1'b0}} - B_LEN'(2), 1'b0, (P_LEN'(3) << 64) - P_LEN'(6));
      add_vec("s_pos",   A_LEN'(1000), B_LEN'(1000), 1'b1, P_LEN'(1000000));

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; tc = 1'b0;
      a = {A_LEN{1'b0}}; b = {B_LEN{1'b0}};
      repeat (2) @(negedge clk);
      check("rst out_valid", P_LEN'(out_valid), {P_LEN{1'b0}});
      check("rst busy", P_LEN'(busy), {P_LEN{1'b0}});
      check("rst p", p, {P_LEN{1'b0}});
      check("rst in_ready", P_LEN'(in_ready), ONE_P);
      rst = 1'b0;

      foreach (vecs[i]) run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].tc, vecs[i].exp);

      // Backpressure: result held, new operands refused, then accepted on the handshake edge
      @(negedge clk);
      a = A_LEN'(12345); b = B_LEN'(678); tc = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      wait_out(lat);
      check("bp latency", P_LEN'(lat), P_LEN'(NCYC));
      for (int i = 0; i < 5; i++) begin
         a = A_ALL; b = B_ALL; tc = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
         #1;
         check("bp hold valid", P_LEN'(out_valid), ONE_P);
         check("bp hold p", p, P_LEN'(8369910));
         check("bp in_ready low", P_LEN'(in_ready), {P_LEN{1'b0}});
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1 check("bp in_ready high", P_LEN'(in_ready), ONE_P);
      @(negedge clk);
      in_valid = 1'b0;
      check("bp valid drop", P_LEN'(out_valid), {P_LEN{1'b0}});
      check("bp busy", P_LEN'(busy), ONE_P);
      wait_out(lat);
      check("bp2 latency", P_LEN'(lat), P_LEN'(NCYC));
      check("bp2 p", p, ONE_P);
      @(negedge clk);

      // Reset in the middle of RUN
      a = A_ALL; b = B_LEN'(99); tc = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst out_valid", P_LEN'(out_valid), {P_LEN{1'b0}});
      check("midrst in_ready", P_LEN'(in_ready), ONE_P);
      check("midrst p", p, {P_LEN{1'b0}});
      check("midrst busy", P_LEN'(busy), {P_LEN{1'b0}});
      @(negedge clk);
      rst = 1'b0;
      run_op("after_rst", A_LEN'(3), B_LEN'(7), 1'b0, P_LEN'(21));

      // Random traffic with random gaps on both sides
      sent = 0; recv = 0; cyc = 0; prev_hold = 1'b0; prev_p = {P_LEN{1'b0}};
      while (recv < NRAND && cyc < 40000) begin
         @(negedge clk);
         cyc++;
         in_valid = (sent < NRAND) && ($urandom_range(0, 3) != 0);
         a = rand_a(); b = rand_b(); tc = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
         if (prev_hold) begin
            check("rand hold valid", P_LEN'(out_valid), ONE_P);
            check("rand hold p", p, prev_p);
         end
         if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL rand spurious: out_valid=1 with no operation outstanding");
            end else begin
               check("rand p", p, expq.pop_front());
            end
            recv++;
         end
         if (in_valid && in_ready) begin
            expq.push_back(ref_mul(a, b, tc));
            sent++;
         end
         prev_hold = out_valid && !out_ready;
         prev_p = p;
      end
      check("rand completed", P_LEN'(recv), P_LEN'(NRAND));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
